// File: rtl/imul53_arb.sv
// imul53_arb: round-robin front end sharing one imul53 between two requesters.
// Define IMUL53_ARB_WDOG_EN to add a WAIT-state watchdog of WDOG_LIMIT cycles.
module imul53_arb #(
    parameter int WDOG_LIMIT = 63
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    input  logic [52:0]  i_req0_a,
    input  logic [52:0]  i_req0_b,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [52:0]  i_req1_a,
    input  logic [52:0]  i_req1_b,
    output logic         o_req1_ready,
    output logic         o_resp0_valid,
    input  logic         i_resp0_ready,
    output logic [105:0] o_resp0_result,
    output logic [6:0]   o_resp0_shift,
    output logic         o_resp0_overflow,
    output logic         o_resp0_err,
    output logic         o_resp1_valid,
    input  logic         i_resp1_ready,
    output logic [105:0] o_resp1_result,
    output logic [6:0]   o_resp1_shift,
    output logic         o_resp1_overflow,
    output logic         o_resp1_err,
    output logic         o_mul_ena,
    output logic [52:0]  o_mul_a,
    output logic [52:0]  o_mul_b,
    input  logic         i_mul_rdy,
    input  logic [105:0] i_mul_result,
    input  logic [6:0]   i_mul_shift,
    input  logic         i_mul_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 127) begin : g_bad_limit
        $error("WDOG_LIMIT must fit the 7-bit watchdog counter");
    end

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [52:0]    a_q, a_d;
    logic [52:0]    b_q, b_d;
    logic [105:0]   res_q, res_d;
    logic [6:0]     shift_q, shift_d;
    logic           ovf_q, ovf_d;
    logic           grant;
    logic           run;
    logic           in_resp;

`ifdef IMUL53_ARB_WDOG_EN
    localparam logic [6:0] WDOG_LAST = 7'(WDOG_LIMIT - 1);
    logic [6:0]     wdog_q, wdog_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        shift_d = shift_q;
        ovf_d   = ovf_q;
`ifdef IMUL53_ARB_WDOG_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        // on a tie the requester that did not win last time goes first
        grant = (i_req0_valid & i_req1_valid) ? ~last_q : i_req1_valid;
        unique case (state_q)
            IDLE: begin
                if (i_req0_valid | i_req1_valid) begin
                    owner_d = grant;
                    last_d  = grant;
                    a_d     = grant ? i_req1_a : i_req0_a;
                    b_d     = grant ? i_req1_b : i_req0_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef IMUL53_ARB_WDOG_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (i_mul_rdy) begin
                    res_d   = i_mul_result;
                    shift_d = i_mul_shift;
                    ovf_d   = i_mul_overflow;
                    state_d = RESP;
`ifdef IMUL53_ARB_WDOG_EN
                    err_d   = 1'b0;
                end else if (wdog_q == WDOG_LAST) begin
                    res_d   = '0;
                    shift_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d  = wdog_q + 7'd1;
`endif
                end
            end
            RESP: begin
                if (owner_q ? i_resp1_ready : i_resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
`ifdef IMUL53_ARB_WDOG_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
`ifdef IMUL53_ARB_WDOG_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    // every output is forced low while reset is held
    assign run     = ~i_rst;
    assign in_resp = run & (state_q == RESP);

    assign o_req0_ready = run & (state_q == IDLE) & i_req0_valid & ~grant;
    assign o_req1_ready = run & (state_q == IDLE) & i_req1_valid & grant;

    assign o_mul_ena = run & (state_q == ISSUE);
    assign o_mul_a   = run ? a_q : '0;
    assign o_mul_b   = run ? b_q : '0;

    assign o_resp0_valid    = in_resp & ~owner_q;
    assign o_resp0_result   = o_resp0_valid ? res_q : '0;
    assign o_resp0_shift    = o_resp0_valid ? shift_q : '0;
    assign o_resp0_overflow = o_resp0_valid & ovf_q;

    assign o_resp1_valid    = in_resp & owner_q;
    assign o_resp1_result   = o_resp1_valid ? res_q : '0;
    assign o_resp1_shift    = o_resp1_valid ? shift_q : '0;
    assign o_resp1_overflow = o_resp1_valid & ovf_q;

`ifdef IMUL53_ARB_WDOG_EN
    assign o_resp0_err = o_resp0_valid & err_q;
    assign o_resp1_err = o_resp1_valid & err_q;
`else
    assign o_resp0_err = 1'b0;
    assign o_resp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_imul53_arb.sv
// tb_imul53_arb: directed and random stimulus against a transaction-level
// model of the two-port imul53 arbiter, with a behavioural imul53 stand-in.
module tb_imul53_arb;

    localparam int WDOG = 63;

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, r0, r1;
    logic [52:0]  a0, b0, a1, b1;
    logic         rv0, rv1, rr0, rr1;
    logic [105:0] res0, res1;
    logic [6:0]   sh0, sh1;
    logic         ov0, ov1, er0, er1;
    logic         ena;
    logic [52:0]  ma, mb;
    logic         mrdy;
    logic [105:0] mres;
    logic [6:0]   msh;
    logic         movf;

    always #5 clk = ~clk;

    imul53_arb #(.WDOG_LIMIT(WDOG)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0),
        .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1),
        .o_req1_ready(r1),
        .o_resp0_valid(rv0), .i_resp0_ready(rr0),
        .o_resp0_result(res0), .o_resp0_shift(sh0),
        .o_resp0_overflow(ov0), .o_resp0_err(er0),
        .o_resp1_valid(rv1), .i_resp1_ready(rr1),
        .o_resp1_result(res1), .o_resp1_shift(sh1),
        .o_resp1_overflow(ov1), .o_resp1_err(er1),
        .o_mul_ena(ena), .o_mul_a(ma), .o_mul_b(mb),
        .i_mul_rdy(mrdy), .i_mul_result(mres),
        .i_mul_shift(msh), .i_mul_overflow(movf)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // reference model: one outstanding transaction at most
    bit           m_act = 0, m_owner = 0, m_last = 1, m_done = 0;
    int           m_cyc = 0;
    logic [52:0]  m_a, m_b;
    logic [105:0] m_res;
    logic [6:0]   m_shift;
    bit           m_ovf, m_err;

    // environment: requesters and imul53 stand-in
    bit           acc0, acc1;
    bit           env_busy = 0;
    int           env_due = 0;
    logic [105:0] env_res;
    logic [6:0]   env_sh;
    bit           env_ovf;
    int           req_mode = 0, p_req = 0, p_rr = 100, p_spur = 0;
    int           fix_lat = 0;
    bit           hang_next = 0, rnd_hang = 0;

    // observation trackers
    int           cnt_r0, cnt_ena, cnt_rv, cnt_rv1;
    int           t_acc, t_resp, t_hs;
    logic [105:0] got_res;
    bit           got_er;
    bit           glog[$];

    function automatic logic [52:0] r53();
        return 53'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                      nm, act, exp, cyc);
    endtask

    task automatic clr();
        cnt_r0 = 0; cnt_ena = 0; cnt_rv = 0; cnt_rv1 = 0;
        t_acc = -1; t_resp = -1; t_hs = -1;
        got_res = '0; got_er = 0;
        glog.delete();
    endtask

    task automatic step();
        bit g, e_r0, e_r1, e_ena, e_rv0, e_rv1;
        int lat;
        @(negedge clk);
        if (rst) begin
            chk("rst_req0_ready", r0, 0);
            chk("rst_req1_ready", r1, 0);
            chk("rst_mul_ena", ena, 0);
            chk("rst_mul_a", ma, 0);
            chk("rst_resp0_valid", rv0, 0);
            chk("rst_resp1_valid", rv1, 0);
            chk("rst_resp0_result", res0, 0);
        end else begin
            g = (v0 && v1) ? !m_last : v1;
            e_r0 = !m_act && v0 && !g;
            e_r1 = !m_act && v1 && g;
            e_ena = m_act && !m_done && m_cyc == 1;
            e_rv0 = m_act && m_done && !m_owner;
            e_rv1 = m_act && m_done && m_owner;
            chk("req0_ready", r0, e_r0);
            chk("req1_ready", r1, e_r1);
            chk("mul_ena", ena, e_ena);
            if (e_ena) begin
                chk("mul_a", ma, m_a);
                chk("mul_b", mb, m_b);
            end
            chk("resp0_valid", rv0, e_rv0);
            chk("resp1_valid", rv1, e_rv1);
            if (e_rv0) begin
                chk("resp0_result", res0, m_res);
                chk("resp0_shift", sh0, m_shift);
                chk("resp0_overflow", ov0, m_ovf);
                chk("resp0_err", er0, m_err);
            end else chk("resp0_err_idle", er0, 0);
            if (e_rv1) begin
                chk("resp1_result", res1, m_res);
                chk("resp1_shift", sh1, m_shift);
                chk("resp1_overflow", ov1, m_ovf);
                chk("resp1_err", er1, m_err);
            end else chk("resp1_err_idle", er1, 0);
        end
        acc0 = r0;
        acc1 = r1;
        if (r0) begin cnt_r0++; glog.push_back(1'b0); end
        if (r1) glog.push_back(1'b1);
        if (r0 || r1) t_acc = cyc;
        if (ena) begin
            cnt_ena++;
            if (hang_next) begin lat = 100; hang_next = 0; end
            else if (rnd_hang && $urandom_range(49) == 0) lat = 100;
            else if (fix_lat > 0) lat = fix_lat;
            else lat = int'($urandom_range(20, 1));
            env_busy = 1;
            env_due = cyc + lat;
            env_res = {53'd0, ma} * {53'd0, mb};
            env_sh = 7'($urandom());
            env_ovf = 1'($urandom());
        end
        if (rv0 || rv1) begin
            cnt_rv++;
            if (t_resp < 0) begin
                t_resp = cyc;
                got_res = rv0 ? res0 : res1;
                got_er = rv0 ? er0 : er1;
            end
        end
        if (rv1) cnt_rv1++;
        if (t_hs < 0 && ((rv0 && rr0) || (rv1 && rr1))) t_hs = cyc;

        @(posedge clk);
        if (rst) begin
            m_act = 0; m_last = 1; m_owner = 0;
        end else if (!m_act) begin
            if (v0 || v1) begin
                g = (v0 && v1) ? !m_last : v1;
                m_act = 1; m_owner = g; m_last = g;
                m_cyc = 1; m_done = 0;
                m_a = g ? a1 : a0;
                m_b = g ? b1 : b0;
            end
        end else if (m_done) begin
            if (m_owner ? rr1 : rr0) m_act = 0;
        end else begin
            if (m_cyc >= 2 && mrdy) begin
                m_done = 1;
                m_res = {53'd0, m_a} * {53'd0, m_b};
                m_shift = msh; m_ovf = movf; m_err = 0;
            end
`ifdef IMUL53_ARB_WDOG_EN
            else if (m_cyc - 1 >= WDOG) begin
                m_done = 1;
                m_res = '0; m_shift = '0; m_ovf = 0; m_err = 1;
            end
`endif
            m_cyc++;
        end
        cyc++;

        #1;
        if (acc0) v0 = 0;
        if (acc1) v1 = 0;
        if (!v0 && (req_mode == 2 ||
            (req_mode == 1 && $urandom_range(99) < p_req))) begin
            v0 = 1; a0 = r53(); b0 = r53();
        end
        if (!v1 && (req_mode == 2 ||
            (req_mode == 1 && $urandom_range(99) < p_req))) begin
            v1 = 1; a1 = r53(); b1 = r53();
        end
        rr0 = $urandom_range(99) < p_rr;
        rr1 = $urandom_range(99) < p_rr;
        if (env_busy && cyc == env_due) begin
            mrdy = 1; mres = env_res; msh = env_sh; movf = env_ovf;
            env_busy = 0;
        end else begin
            mrdy = !env_busy && ($urandom_range(99) < p_spur);
            mres = {r53(), r53()};
            msh = 7'($urandom());
            movf = 1'($urandom());
        end
    endtask

    initial begin
        logic [105:0] big;
        logic [52:0]  one52;
        rst = 1; v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        mrdy = 0; mres = '0; msh = '0; movf = 0;
        clr();

        // single request, 16-cycle multiplier
        repeat (2) step();
        one52 = 53'd1 << 52;
        v0 = 1; a0 = one52; b0 = one52;
        step();
        rst = 0; fix_lat = 16; p_spur = 25; clr();
        repeat (30) step();
        big = 106'd1 << 104;
        chk("r031_ready_pulses", cnt_r0, 1);
        chk("r031_ena_pulses", cnt_ena, 1);
        chk("r031_latency", t_resp - t_acc, 18);
        chk("r031_result", got_res, big);
        chk("r031_err", got_er, 0);

        // both requesters always valid: round-robin order
        rst = 1; req_mode = 2; fix_lat = 1;
        repeat (2) step();
        rst = 0; clr();
        repeat (40) step();
        chk("r032_ngrants", glog.size() >= 3, 1);
        if (glog.size() >= 3) begin
            chk("r032_grant0", glog[0], 0);
            chk("r032_grant1", glog[1], 1);
            chk("r032_grant2", glog[2], 0);
        end

        // response back-pressure on requester 1
        rst = 1; req_mode = 0; v0 = 0; v1 = 0;
        p_rr = 0; rr0 = 0; rr1 = 0; fix_lat = 2;
        step();
        rst = 0; v1 = 1; a1 = r53(); b1 = r53(); clr();
        for (int i = 0; i < 40 && t_resp < 0; i++) step();
        chk("r033_resp_seen", t_resp >= 0, 1);
        v0 = 1; a0 = r53(); b0 = r53();
        repeat (10) step();
        chk("r033_hold_cycles", cnt_rv1, 11);
        chk("r033_no_accept", cnt_r0, 0);
        p_rr = 100; rr0 = 1; rr1 = 1;
        repeat (3) step();
        chk("r033_accept_after_hs", t_acc - t_hs, 1);

        // reset in WAIT, late multiplier strobe
        rst = 1; v0 = 0; v1 = 0; fix_lat = 10; p_spur = 0;
        step();
        rst = 0; v0 = 1; a0 = r53(); b0 = r53(); clr();
        repeat (6) step();
        chk("r034_issued", cnt_ena, 1);
        rst = 1;
        step();
        rst = 0; clr();
        repeat (15) step();
        chk("r034_no_resp", cnt_rv, 0);
        v0 = 1; a0 = r53(); b0 = r53(); fix_lat = 3; clr();
        repeat (10) step();
        chk("r034_reaccept", cnt_r0, 1);
        chk("r034_latency", t_resp - t_acc, 5);

        // multiplier that does not answer for 100 cycles
        rst = 1; v0 = 0;
        step();
        rst = 0; hang_next = 1; v0 = 1; a0 = r53(); b0 = r53(); clr();
        repeat (110) step();
`ifdef IMUL53_ARB_WDOG_EN
        chk("r035_wdog_latency", t_resp - t_acc, 2 + WDOG);
        chk("r035_err", got_er, 1);
        chk("r035_result_zero", got_res, 0);
`else
        chk("r035_wait_latency", t_resp - t_acc, 102);
        chk("r035_err", got_er, 0);
`endif

        // random traffic with spurious strobes, stalls and resets
        rst = 1;
        step();
        rst = 0; req_mode = 1; p_req = 35; p_rr = 60;
        p_spur = 15; fix_lat = 0; rnd_hang = 1; clr();
        repeat (4000) begin
            step();
            rst = ($urandom_range(399) == 0);
        end
        chk("rnd_activity", cnt_ena > 100, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imul53_arb.md
IMUL53_ARB -- requirements
Module: imul53_arb

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 63: maximum number of WAIT cycles before the watchdog aborts a multiply.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have, for each n in {0,1}, port i_reqn_valid, input, 1 bit: requester n presents operands.
REQ-005 SHALL have, for each n, port i_reqn_a, input, 53 bits: mantissa A for requester n.
REQ-006 SHALL have, for each n, port i_reqn_b, input, 53 bits: mantissa B for requester n.
REQ-007 SHALL have, for each n, port o_reqn_ready, output, 1 bit: request accepted this cycle.
REQ-008 SHALL have, for each n, port o_respn_valid, output, 1 bit: result available for requester n.
REQ-009 SHALL have, for each n, port i_respn_ready, input, 1 bit: requester n consumes the result.
REQ-010 SHALL have, for each n, ports o_respn_result (106 bits), o_respn_shift (7 bits), o_respn_overflow (1 bit) and o_respn_err (1 bit), all outputs: returned product fields.
REQ-011 SHALL have ports o_mul_ena (output, 1 bit), o_mul_a (output, 53 bits) and o_mul_b (output, 53 bits): the start pulse and operands to the shared imul53.
REQ-012 SHALL have ports i_mul_rdy (input, 1 bit), i_mul_result (input, 106 bits), i_mul_shift (input, 7 bits) and i_mul_overflow (input, 1 bit): the completion strobe and results from imul53.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT and RESP, plus a 1-bit owner register and a 1-bit last-grant register.
REQ-014 In IDLE, SHALL grant one valid requester and drive its o_reqn_ready=1 combinationally; all other ready outputs are 0.
REQ-015 When both requesters are valid in IDLE, SHALL grant the requester not equal to last-grant (round-robin).
REQ-016 On a grant, SHALL latch the operands into o_mul_a/o_mul_b, set owner and last-grant to the granted requester, and go to ISSUE.
REQ-017 In ISSUE, SHALL drive o_mul_ena=1 for exactly one cycle and then go to WAIT; o_mul_ena SHALL be 0 in every other state.
REQ-018 In WAIT, SHALL capture i_mul_result, i_mul_shift and i_mul_overflow into the response registers when i_mul_rdy=1, then go to RESP.
REQ-019 SHALL ignore i_mul_rdy in IDLE, ISSUE and RESP.
REQ-020 In RESP, SHALL hold o_resp[owner]_valid=1 and stable response data until i_resp[owner]_ready=1, then return to IDLE on the next edge.
REQ-021 SHALL keep the non-owner o_respn_valid at 0 at all times.
REQ-022 SHALL drive o_reqn_ready=0 in ISSUE, WAIT and RESP; a requester keeps valid asserted until it is accepted.
REQ-023 Minimum latency from acceptance to o_respn_valid SHALL be 2 cycles plus the imul53 latency.
REQ-024 SHALL guarantee that a requester held valid is granted within one other transaction (no starvation).
REQ-025 SHALL hold o_respn_err=0 unless the watchdog fires (REQ-029).

Reset
REQ-026 When i_rst=1 on a clock edge, SHALL enter IDLE with last-grant=1 (so requester 0 wins the first tie), owner=0, and operand and response registers cleared.
REQ-027 While in reset, SHALL drive every output to 0.
REQ-028 Reset asserted mid-transaction SHALL drop the transaction; an i_mul_rdy arriving after reset SHALL be ignored.

Configuration
REQ-029 With macro IMUL53_ARB_WDOG_EN defined, a 7-bit counter SHALL count WAIT cycles; on reaching WDOG_LIMIT without i_mul_rdy, SHALL go to RESP with result, shift and overflow all 0 and o_resp[owner]_err=1.
REQ-030 Without IMUL53_ARB_WDOG_EN, no counter SHALL exist, WAIT SHALL last until i_mul_rdy, and o_respn_err SHALL be tied to 0.

Verification
REQ-031 req0 valid, a=1<<52, b=1<<52, imul53 model returns after 16 cycles -> o_req0_ready pulses once, one o_mul_ena pulse, o_resp0_valid with result=1<<104 and err=0.
REQ-032 req0 and req1 both valid from the cycle after reset, 3 back-to-back transactions -> grant order 0,1,0 and each response is routed only to its owner.
REQ-033 i_resp1_ready held low for 10 cycles in RESP -> o_resp1_valid and data stay stable; a new req0 is not accepted until the cycle after the handshake.
REQ-034 i_rst pulsed for 1 cycle in WAIT, then a late i_mul_rdy -> no response is produced and the next request is accepted normally.
REQ-035 IMUL53_ARB_WDOG_EN defined and imul53 never asserts rdy -> o_resp0_valid with err=1 after 63 WAIT cycles; without the macro, the block stays in WAIT.
REQ-036 i_mul_rdy injected during IDLE and ISSUE -> no state change and no response.
